// File: rtl/fp_prep_pkg.sv
// rtl/fp_prep_pkg.sv - shared types and sizing for the FP adder operand-preparation stage
//   EXP_W_DEF / MAN_W_DEF : default exponent / stored-fraction widths
//   align_w()             : width of the aligned significand field
//   fp_cls_e              : operand class
//   fp_dec_t              : decoded operand at default widths
package fp_prep_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // One carry-headroom bit, hidden+fraction, then MAN_W+2 guard bits.
  function automatic int align_w(input int man_w);
    return 2 * man_w + 4;
  endfunction

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORM   = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_cls_e;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] eff_exp;
    logic [MAN_W_DEF:0]   sig;
    fp_cls_e              cls;
  } fp_dec_t;

endpackage

// File: rtl/fp_decoder.sv
// rtl/fp_decoder.sv - combinational decode of one {sign, exp, frac} operand
//   op      : packed operand
//   sign    : sign bit as stored
//   eff_exp : exponent, with zero/denormal mapped to 1
//   sig     : {hidden, frac}
//   cls     : fp_cls_e encoding
module fp_decoder
  import fp_prep_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     eff_exp,
  output logic [MAN_W:0]       sig,
  output logic [2:0]           cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac;
  fp_cls_e          cls_e;

  assign sign  = op[EXP_W+MAN_W];
  assign exp_f = op[EXP_W+MAN_W-1:MAN_W];
  assign frac  = op[MAN_W-1:0];
  assign cls   = cls_e;

  always_comb begin
    cls_e   = CLS_NORM;
    eff_exp = exp_f;
    sig     = {1'b1, frac};
    if (exp_f == '1) begin
      cls_e = (frac != '0) ? CLS_NAN : CLS_INF;
    end else if (exp_f == '0) begin
      // Denormals share the scale of exponent 1, just without the hidden bit.
      cls_e   = (frac != '0) ? CLS_DENORM : CLS_ZERO;
      eff_exp = EXP_W'(1);
      sig     = {1'b0, frac};
    end
  end

endmodule

// File: rtl/fp_add_prep_pipe.sv
// rtl/fp_add_prep_pipe.sv - two-stage operand classify/order/align pipeline for the FP adder
//   clk, rst_n (async, active-low), flush (sync, drops in-flight entries)
//   in_valid/in_ready, op_1, op_2, op_sub, in_tag : input handshake and operands
//   out_valid/out_ready : output handshake
//   nan_res, inf_res, res_sig, eff_sub, exp_max, mant_a, mant_b, sticky_b, out_tag : prepared result
module fp_add_prep_pipe
  import fp_prep_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_1,
  input  logic [EXP_W+MAN_W:0]   op_2,
  input  logic                   op_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   nan_res,
  output logic                   inf_res,
  output logic                   res_sig,
  output logic                   eff_sub,
  output logic [EXP_W-1:0]       exp_max,
  output logic [2*MAN_W+3:0]     mant_a,
  output logic [2*MAN_W+3:0]     mant_b,
  output logic                   sticky_b,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int ALIGN_W = align_w(MAN_W);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [MAN_W:0]   sig;
    logic [2:0]       cls;
  } dec_t;

  // ---------------- handshake ----------------
  logic s1_v;
  logic s1_en, s2_en;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_v || s2_en;
  assign in_ready = s1_en;

  // ---------------- stage 1: decode, compare, swap ----------------
  dec_t d1, d2, da, db;
  logic sign_2_eff;
  logic swap, tie;

  fp_decoder #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_1 (
    .op(op_1), .sign(d1.sign), .eff_exp(d1.eff_exp), .sig(d1.sig), .cls(d1.cls)
  );

  fp_decoder #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_2 (
    .op(op_2), .sign(d2.sign), .eff_exp(d2.eff_exp), .sig(d2.sig), .cls(d2.cls)
  );

  assign sign_2_eff = d2.sign ^ op_sub;
  // op_1 wins ties, so only a strictly larger op_2 swaps.
  assign swap = {d2.eff_exp, d2.sig} > {d1.eff_exp, d1.sig};
  assign tie  = {d2.eff_exp, d2.sig} == {d1.eff_exp, d1.sig};
  assign da   = swap ? d2 : d1;
  assign db   = swap ? d1 : d2;

  logic             s1_sign_1, s1_sign_2, s1_sign_a, s1_neg_both, s1_tie;
  logic [2:0]       s1_cls_1, s1_cls_2;
  logic [EXP_W-1:0] s1_exp_a, s1_d;
  logic [MAN_W:0]   s1_sig_a, s1_sig_b;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign_1   <= 1'b0;
      s1_sign_2   <= 1'b0;
      s1_sign_a   <= 1'b0;
      s1_neg_both <= 1'b0;
      s1_tie      <= 1'b0;
      s1_cls_1    <= '0;
      s1_cls_2    <= '0;
      s1_exp_a    <= '0;
      s1_d        <= '0;
      s1_sig_a    <= '0;
      s1_sig_b    <= '0;
      s1_tag      <= '0;
    end else if (s1_en) begin
      s1_sign_1   <= d1.sign;
      s1_sign_2   <= sign_2_eff;
      s1_sign_a   <= swap ? sign_2_eff : d1.sign;
      // Stored (pre-inversion) signs: -x - (-x) keeps a negative zero.
      s1_neg_both <= d1.sign & d2.sign;
      s1_tie      <= tie;
      s1_cls_1    <= d1.cls;
      s1_cls_2    <= d2.cls;
      s1_exp_a    <= da.eff_exp;
      s1_d        <= da.eff_exp - db.eff_exp;
      s1_sig_a    <= da.sig;
      s1_sig_b    <= db.sig;
      s1_tag      <= in_tag;
    end
  end

  // ---------------- stage 2: specials, sign, align, sticky ----------------
  logic                   nan_1, nan_2, inf_1, inf_2;
  logic                   eff_sub_c, nan_c, inf_c, res_sig_c;
  logic [ALIGN_W-1:0]     layout_a, layout_b, mant_b_c;
  logic [2*ALIGN_W-1:0]   wide;
  logic                   sticky_c;

  assign nan_1     = s1_cls_1 == CLS_NAN;
  assign nan_2     = s1_cls_2 == CLS_NAN;
  assign inf_1     = s1_cls_1 == CLS_INF;
  assign inf_2     = s1_cls_2 == CLS_INF;
  assign eff_sub_c = s1_sign_1 ^ s1_sign_2;
  assign nan_c     = nan_1 || nan_2 || (inf_1 && inf_2 && eff_sub_c);
  assign inf_c     = (inf_1 || inf_2) && !nan_c;

  always_comb begin
    res_sig_c = s1_sign_a;
    if (nan_c)                    res_sig_c = 1'b0;
    else if (inf_c)               res_sig_c = inf_1 ? s1_sign_1 : s1_sign_2;
    else if (s1_tie && eff_sub_c) res_sig_c = s1_neg_both;
  end

  assign layout_a = {1'b0, s1_sig_a, {(MAN_W+2){1'b0}}};
  assign layout_b = {1'b0, s1_sig_b, {(MAN_W+2){1'b0}}};
  // Shifting a double-width field keeps the bits that fall off in the low half.
  assign wide     = {layout_b, {ALIGN_W{1'b0}}} >> s1_d;

  always_comb begin
    mant_b_c = wide[2*ALIGN_W-1:ALIGN_W];
    sticky_c = |wide[ALIGN_W-1:0];
    if (32'(s1_d) >= 32'(ALIGN_W)) begin
      mant_b_c = '0;
      sticky_c = |s1_sig_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_res  <= 1'b0;
      inf_res  <= 1'b0;
      res_sig  <= 1'b0;
      eff_sub  <= 1'b0;
      exp_max  <= '0;
      mant_a   <= '0;
      mant_b   <= '0;
      sticky_b <= 1'b0;
      out_tag  <= '0;
    end else if (s2_en) begin
      nan_res  <= nan_c;
      inf_res  <= inf_c;
      res_sig  <= res_sig_c;
      eff_sub  <= eff_sub_c;
      exp_max  <= s1_exp_a;
      mant_a   <= layout_a;
      mant_b   <= mant_b_c;
      sticky_b <= sticky_c;
      out_tag  <= s1_tag;
    end
  end

  // ---------------- valid bits ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_en) s1_v      <= in_valid;
      if (s2_en) out_valid <= s1_v;
    end
  end

endmodule

// File: doc/fp_add_prep_pipe.md
# fp_add_prep_pipe

Pipelined, parametrised operand-preparation stage for the floating-point adder. It accepts two IEEE-754-style operands plus an add/sub mode and classifies special values. It aligns the significands into a wide field, ordering them so the larger magnitude is first, and hands the result over a valid/ready handshake to the adder/normaliser stage. It replaces the single-cycle FP32-only preparer.

## Interface
- `EXP_W`, 8: exponent width.
- `MAN_W`, 23: stored fraction width.
- `TAG_W`, 4: sideband tag width, passed through unchanged.
- `ALIGN_W`: derived as 2*MAN_W+4 (50 at defaults), not overridable.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset; one clock, asynchronous, active-low.
- `flush  in  1`: synchronous; drops all in-flight entries.
- `in_valid  in  1`; `in_ready  out  1`: input handshake.
- `op_1`, `op_2  in  1+EXP_W+MAN_W`: operands {sign, exp, frac}.
- `op_sub  in  1`: 1 computes op_1 − op_2.
- `in_tag  in  TAG_W`.
- `out_valid  out  1`; `out_ready  in  1`: output handshake.
- `nan_res`, `inf_res  out  1`: special result.
- `res_sig  out  1`: result sign.
- `eff_sub  out  1`: effective subtraction.
- `exp_max  out  EXP_W`: larger effective exponent.
- `mant_a  out  ALIGN_W`: larger-magnitude significand.
- `mant_b  out  ALIGN_W`: smaller-magnitude significand, aligned.
- `sticky_b  out  1`: OR of the bits of the smaller significand shifted below bit 0.
- `out_tag  out  TAG_W`.

## Operation
- Decode each operand:
  - exp all-ones with frac≠0: NaN.
  - exp all-ones with frac=0: Inf.
  - exp=0: zero or denormal; hidden bit 0, effective exponent 1.
  - otherwise normal; hidden bit 1.
- op_2 sign is inverted when `op_sub`=1.
- `eff_sub` = sign_1 XOR sign_2 (after the inversion).
- Specials:
  - `nan_res`=1 if either operand is NaN, or both are Inf with `eff_sub`=1.
  - `inf_res`=1 if either operand is Inf and `nan_res`=0.
  - In the Inf case `res_sig` = sign of the Inf operand.
  - When `nan_res`=1, `res_sig`=0 and the mantissa outputs are don't-care but deterministic.
- Ordering: compare {eff_exp, hidden, frac}. The larger operand is A; on an exact tie, op_1 is A.
- `res_sig`:
  - Non-special cases: sign of A.
  - Exact tie with `eff_sub`=1: `res_sig`=0, except when both signs are 1, then `res_sig`=1.
- Significand layout in ALIGN_W: bit ALIGN_W−1 = 0 (carry headroom); bits [ALIGN_W−2 −: MAN_W+1] = {hidden, frac}; low MAN_W+2 bits = 0.
- `mant_b` = B layout shifted right by d = eff_exp_A − eff_exp_B.
  - If d ≥ ALIGN_W, `mant_b`=0 and `sticky_b` = (B significand ≠ 0).
- `exp_max` = eff_exp_A. Both operands zero gives `exp_max`=1.

## Timing
- Two pipeline stages; latency 2 cycles from an accepted input to `out_valid`; throughput 1 per cycle.
- Stage 1 registers decode, class, exponent compare, swap select and d. Stage 2 registers the shift, sticky, sign and special flags.
- Stall rules, bubble-collapsing:
  - s2_en = !s2_v | out_ready
  - s1_en = !s1_v | s2_en
  - in_ready = s1_en
  - The combinational path out_ready→in_ready is permitted.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- Entries never reorder or duplicate; a transfer occurs only on valid&ready.
- `flush`: next edge clears s1_v and s2_v. An input presented in the flush cycle is discarded.
- Reset: async assertion clears s1_v and s2_v and all output registers to 0, including `out_tag` and `exp_max`. `in_ready`=1 from the first cycle after deassertion. In-flight data is lost.

## Structure
- Package `fp_prep_pkg`:
  - `EXP_W`/`MAN_W` defaults and the ALIGN_W function.
  - Class enum {ZERO, DENORM, NORM, INF, NAN}.
  - Packed decoded-operand struct {sign, eff_exp, sig, cls}.
- Sub-module `fp_decoder` (parametrised, combinational), instantiated twice in stage 1.
- Alignment shifter and sticky logic stay inline in stage 2.

## Test plan
- 0x3F800000 + 0x40000000, `op_sub`=0 → after 2 cycles:
  - `exp_max`=0x80.
  - `mant_a`=0x1_0000_0000_0000, `mant_b`=0x8000_0000_0000.
  - `sticky_b`=0, `eff_sub`=0, `res_sig`=0.
- 0x7F800000 − 0x7F800000 (`op_sub`=1) → `nan_res`=1, `inf_res`=0.
- 0x7F800000 − 0xFF800000 (`op_sub`=1) → `inf_res`=1, `res_sig`=0.
- 0x3F800000 + 0x21800000 (d=60):
  - `mant_b`=0, `sticky_b`=1, `exp_max`=0x7F.
- 0x3F800000 − 0x3F800000 → `eff_sub`=1, `res_sig`=0, `mant_a`==`mant_b`.
- 0xBF800000 + 0x3F800000 → tie with `eff_sub`=1 and one negative sign: `res_sig`=0.
- Backpressure:
  - Issue tags 1,2,3 back-to-back with `out_ready`=0 → `in_ready` falls after tags 1 and 2 are held.
  - Tag 1 is held stable on the outputs.
  - Raising `out_ready` drains tags 1,2,3 in order with no loss.
- Mid-flight `rst_n` pulse and `flush` pulse → `out_valid`=0 next cycle; no stale tag emerges afterwards.
